// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: one FSM sequencing a shared ALU and a unified
// memory port, with a request/ready handshake, wait timeout and sticky trap.
//
// state  | meaning
// -------+-------------------------------------------------------------
// START  | idle after reset, all outputs low
// FETCH  | read instruction at PC, PC+4 into PC when memory is ready
// DECODE | compute branch target into ALUOut, dispatch on op/funct
// MEMADR | compute load/store address base+signimm
// MEMRD  | load data read, address from ALUOut
// MEMWB  | write loaded data to rt
// MEMWR  | store (word or byte lane) to ALUOut address
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result to rd
// BRANCH | compare A-B, take target from ALUOut on beq/bne condition
// ADDIEX | A + signimm
// ADDIWB | write addi result to rt
// JUMP   | load jump target into PC
// TRAP   | illegal instruction or memory timeout, held until reset
module mips_mc_controller #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       memready,
   output logic       memreq,
   output logic       memwrite,
   output logic       sb,
   output logic       iord,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alucontrol,
   output logic       shift,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic       fault,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      START  = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
      MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC   = 4'd7,
      ALUWB  = 4'd8,  BRANCH = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
      JUMP   = 4'd12, TRAP   = 4'd15
   } state_t;

   // Terminal count of the wait counter; unused when the timeout is disabled.
   localparam logic [CNT_W-1:0] WAIT_TC = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   state_t           cur;
   state_t           nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic             mem_state;
   logic             timed_out;
   logic             rtype_ok;

   assign state     = cur;
   assign mem_state = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
   assign timed_out = (TIMEOUT != 0) && mem_state && !memready && (wait_cnt == WAIT_TC);

   // Supported R-type function codes.
   always_comb begin
      rtype_ok = 1'b0;
      case (funct)
         6'b100000, 6'b100010, 6'b100100,
         6'b100101, 6'b101010, 6'b000000: rtype_ok = 1'b1;
         default:                         rtype_ok = 1'b0;
      endcase
   end

   // Next-state selection; an expired memory wait overrides everything.
   always_comb begin
      nxt = cur;
      case (cur)
         START:  nxt = FETCH;
         FETCH:  if (memready) nxt = DECODE;
         DECODE: begin
            case (op)
               6'b000000:                       nxt = rtype_ok ? EXEC : TRAP;
               6'b100011, 6'b101011, 6'b101000: nxt = MEMADR;
               6'b000100, 6'b000101:            nxt = BRANCH;
               6'b001000:                       nxt = ADDIEX;
               6'b000010:                       nxt = JUMP;
               default:                         nxt = TRAP;
            endcase
         end
         MEMADR: nxt = (op == 6'b100011) ? MEMRD : MEMWR;
         MEMRD:  if (memready) nxt = MEMWB;
         MEMWB:  nxt = FETCH;
         MEMWR:  if (memready) nxt = FETCH;
         EXEC:   nxt = ALUWB;
         ALUWB:  nxt = FETCH;
         BRANCH: nxt = FETCH;
         ADDIEX: nxt = ADDIWB;
         ADDIWB: nxt = FETCH;
         JUMP:   nxt = FETCH;
         TRAP:   nxt = TRAP;
         default: nxt = TRAP;
      endcase
      if (timed_out) nxt = TRAP;
   end

   // State register and wait counter (cleared on any state change, saturating).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur      <= START;
         wait_cnt <= '0;
      end else begin
         cur <= nxt;
         if (nxt != cur)
            wait_cnt <= '0;
         else if (mem_state && !memready && (wait_cnt != '1))
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Control outputs decoded from the current state and live inputs.
   always_comb begin
      memreq     = 1'b0;
      memwrite   = 1'b0;
      sb         = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      alucontrol = 3'b000;
      shift      = 1'b0;
      pcsrc      = 2'b00;
      pcen       = 1'b0;
      fault      = 1'b0;
      case (cur)
         FETCH: begin
            memreq     = 1'b1;
            alusrcb    = 2'b01;
            alucontrol = 3'b010;
            irwrite    = memready;
            pcen       = memready;
         end
         DECODE: begin
            alusrcb    = 2'b11;
            alucontrol = 3'b010;
         end
         MEMADR, ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alucontrol = 3'b010;
         end
         MEMRD: begin
            memreq = 1'b1;
            iord   = 1'b1;
         end
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         MEMWR: begin
            memreq   = 1'b1;
            memwrite = 1'b1;
            iord     = 1'b1;
            sb       = (op == 6'b101000);
         end
         EXEC: begin
            alusrca = 1'b1;
            case (funct)
               6'b100000: alucontrol = 3'b010;
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               6'b000000: begin
                  alucontrol = 3'b011;
                  shift      = 1'b1;
               end
               default:   alucontrol = 3'b000;
            endcase
         end
         ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = 3'b110;
            pcsrc      = 2'b01;
            pcen       = (op == 6'b000100) ? zero : ~zero;
         end
         ADDIWB:  regwrite = 1'b1;
         JUMP: begin
            pcsrc = 2'b10;
            pcen  = 1'b1;
         end
         TRAP:    fault = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller with a short (4-cycle) memory timeout.
module tb_mips_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       memready;
   logic       memreq, memwrite, sb, iord, irwrite, regdst, memtoreg, regwrite;
   logic       alusrca, shift, pcen, fault;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;
   logic [18:0] ctl;

   int checks = 0;
   int errors = 0;

   localparam logic [3:0] S_START = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                          S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
                          S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
                          S_JUMP = 4'd12, S_TRAP = 4'd15;

   localparam logic [18:0] MREQ = 19'd1 << 18, MWR = 19'd1 << 17, SBB = 19'd1 << 16,
                           IORD = 19'd1 << 15, IRW = 19'd1 << 14, RDST = 19'd1 << 13,
                           M2R = 19'd1 << 12, RWR = 19'd1 << 11, SRCA = 19'd1 << 10,
                           B01 = 19'd1 << 8, B10 = 19'd2 << 8, B11 = 19'd3 << 8,
                           A_ADD = 19'd2 << 5, A_SUB = 19'd6 << 5, A_AND = 19'd0,
                           A_OR = 19'd1 << 5, A_SLT = 19'd7 << 5, A_SLL = 19'd3 << 5,
                           SHF = 19'd1 << 4, PC01 = 19'd1 << 2, PC10 = 19'd2 << 2,
                           PCEN = 19'd1 << 1, FLT = 19'd1;
   localparam logic [18:0] C0 = 19'd0;
   localparam logic [18:0] F_W = MREQ | B01 | A_ADD;
   localparam logic [18:0] F_RDY = F_W | IRW | PCEN;
   localparam logic [18:0] DEC = B11 | A_ADD;
   localparam logic [18:0] MADR = SRCA | B10 | A_ADD;
   localparam logic [18:0] MRD = MREQ | IORD;
   localparam logic [18:0] MWRC = MREQ | MWR | IORD;

   assign ctl = {memreq, memwrite, sb, iord, irwrite, regdst, memtoreg, regwrite,
                 alusrca, alusrcb, alucontrol, shift, pcsrc, pcen, fault};

   mips_mc_controller #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
      .memreq(memreq), .memwrite(memwrite), .sb(sb), .iord(iord), .irwrite(irwrite),
      .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
      .alusrcb(alusrcb), .alucontrol(alucontrol), .shift(shift), .pcsrc(pcsrc),
      .pcen(pcen), .fault(fault), .state(state)
   );

   always #5 clk = ~clk;

   // Hold reset for two cycles, release on a falling edge: DUT sits in START.
   task automatic apply_reset();
      reset    = 1'b0;
      memready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      op = 6'b000000; funct = 6'b100000; zero = 1'b1;
      reset = 1'b0; memready = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (state !== S_START || ctl !== C0) begin
         errors++;
         $display("FAIL reset_low: state %0d ctl %h, required state %0d ctl %h", state, ctl, S_START, C0);
      end
      @(negedge clk);
      reset = 1'b1; #1;
      checks++;
      if (state !== S_START || ctl !== C0) begin
         errors++;
         $display("FAIL reset_release: state %0d ctl %h, required state %0d ctl %h", state, ctl, S_START, C0);
      end
   endtask

   task automatic test_rtype_add();
      logic [3:0] es[$]; logic [18:0] ec[$]; bit rd[$];
      op = 6'b000000; funct = 6'b100000; zero = 1'b0;
      es = '{S_START, S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_FETCH};
      ec = '{C0, F_RDY, DEC, SRCA | A_ADD, RDST | RWR, F_RDY};
      rd = '{1, 1, 1, 1, 1, 1};
      apply_reset();
      foreach (es[i]) begin
         memready = rd[i]; #1;
         checks++;
         if (state !== es[i] || ctl !== ec[i]) begin
            errors++;
            $display("FAIL rtype_add cyc %0d: state %0d ctl %h, required state %0d ctl %h", i, state, ctl, es[i], ec[i]);
         end
         @(negedge clk);
      end
   endtask

   // The 4th FETCH cycle reaches the timeout compare value with memready=1: no trap.
   task automatic test_lw_wait();
      logic [3:0] es[$]; logic [18:0] ec[$]; bit rd[$];
      op = 6'b100011; funct = 6'b000000; zero = 1'b0;
      es = '{S_START, S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEMADR,
             S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB, S_FETCH};
      ec = '{C0, F_W, F_W, F_W, F_RDY, DEC, MADR, MRD, MRD, MRD, M2R | RWR, F_RDY};
      rd = '{1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
      apply_reset();
      foreach (es[i]) begin
         memready = rd[i]; #1;
         checks++;
         if (state !== es[i] || ctl !== ec[i]) begin
            errors++;
            $display("FAIL lw_wait cyc %0d: state %0d ctl %h, required state %0d ctl %h", i, state, ctl, es[i], ec[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      logic [3:0] es[$]; logic [18:0] ec[$];
      for (int k = 0; k < 4; k++) begin
         op   = (k < 2) ? 6'b000100 : 6'b000101;
         zero = k[0];
         funct = 6'b000000;
         es = '{S_START, S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
         ec = '{C0, F_RDY, DEC,
                SRCA | A_SUB | PC01 | (((k < 2) == k[0]) ? PCEN : C0), F_RDY};
         apply_reset();
         foreach (es[i]) begin
            memready = 1'b1; #1;
            checks++;
            if (state !== es[i] || ctl !== ec[i]) begin
               errors++;
               $display("FAIL branch k%0d cyc %0d: state %0d ctl %h, required state %0d ctl %h", k, i, state, ctl, es[i], ec[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_store();
      logic [3:0] es[$]; logic [18:0] ec[$];
      for (int k = 0; k < 2; k++) begin
         op = (k == 0) ? 6'b101000 : 6'b101011;
         funct = 6'b000000; zero = 1'b0;
         es = '{S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_FETCH};
         ec = '{C0, F_RDY, DEC, MADR, MWRC | ((k == 0) ? SBB : C0), F_RDY};
         apply_reset();
         foreach (es[i]) begin
            memready = 1'b1; #1;
            checks++;
            if (state !== es[i] || ctl !== ec[i]) begin
               errors++;
               $display("FAIL store k%0d cyc %0d: state %0d ctl %h, required state %0d ctl %h", k, i, state, ctl, es[i], ec[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_alu_functs();
      logic [5:0]  ft[6];
      logic [18:0] ex[6];
      ft = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
      ex = '{SRCA | A_ADD, SRCA | A_SUB, SRCA | A_AND, SRCA | A_OR, SRCA | A_SLT, SRCA | A_SLL | SHF};
      for (int k = 0; k < 6; k++) begin
         op = 6'b000000; funct = ft[k]; zero = 1'b0;
         apply_reset();
         memready = 1'b1;
         repeat (3) @(negedge clk);
         #1;
         checks++;
         if (state !== S_EXEC || ctl !== ex[k]) begin
            errors++;
            $display("FAIL exec funct %b: state %0d ctl %h, required state %0d ctl %h", ft[k], state, ctl, S_EXEC, ex[k]);
         end
         @(negedge clk); #1;
         checks++;
         if (state !== S_ALUWB || ctl !== (RDST | RWR)) begin
            errors++;
            $display("FAIL aluwb funct %b: state %0d ctl %h, required state %0d ctl %h", ft[k], state, ctl, S_ALUWB, RDST | RWR);
         end
      end
   endtask

   task automatic test_addi_jump();
      logic [3:0] es[$]; logic [18:0] ec[$];
      for (int k = 0; k < 2; k++) begin
         funct = 6'b000000; zero = 1'b0;
         if (k == 0) begin
            op = 6'b001000;
            es = '{S_START, S_FETCH, S_DECODE, S_ADDIEX, S_ADDIWB, S_FETCH};
            ec = '{C0, F_RDY, DEC, MADR, RWR, F_RDY};
         end else begin
            op = 6'b000010;
            es = '{S_START, S_FETCH, S_DECODE, S_JUMP, S_FETCH};
            ec = '{C0, F_RDY, DEC, PC10 | PCEN, F_RDY};
         end
         apply_reset();
         foreach (es[i]) begin
            memready = 1'b1; #1;
            checks++;
            if (state !== es[i] || ctl !== ec[i]) begin
               errors++;
               $display("FAIL addi_jump k%0d cyc %0d: state %0d ctl %h, required state %0d ctl %h", k, i, state, ctl, es[i], ec[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_timeout();
      logic [3:0] es[$]; logic [18:0] ec[$]; bit rd[$];
      op = 6'b000000; funct = 6'b100000; zero = 1'b0;
      es = '{S_START, S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_TRAP, S_TRAP, S_TRAP};
      ec = '{C0, F_W, F_W, F_W, F_W, FLT, FLT, FLT};
      rd = '{0, 0, 0, 0, 0, 0, 0, 1};
      apply_reset();
      foreach (es[i]) begin
         memready = rd[i]; #1;
         checks++;
         if (state !== es[i] || ctl !== ec[i]) begin
            errors++;
            $display("FAIL timeout cyc %0d: state %0d ctl %h, required state %0d ctl %h", i, state, ctl, es[i], ec[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_illegal();
      logic [3:0] es[$]; logic [18:0] ec[$];
      for (int k = 0; k < 2; k++) begin
         op    = (k == 0) ? 6'b111111 : 6'b000000;
         funct = (k == 0) ? 6'b100000 : 6'b111111;
         zero  = 1'b0;
         es = '{S_START, S_FETCH, S_DECODE, S_TRAP, S_TRAP};
         ec = '{C0, F_RDY, DEC, FLT, FLT};
         apply_reset();
         foreach (es[i]) begin
            memready = 1'b1; #1;
            checks++;
            if (state !== es[i] || ctl !== ec[i]) begin
               errors++;
               $display("FAIL illegal k%0d cyc %0d: state %0d ctl %h, required state %0d ctl %h", k, i, state, ctl, es[i], ec[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset_midwr();
      op = 6'b101000; funct = 6'b000000; zero = 1'b0;
      apply_reset();
      memready = 1'b1;
      repeat (4) @(negedge clk);
      memready = 1'b0; #1;
      checks++;
      if (state !== S_MEMWR || ctl !== (MWRC | SBB)) begin
         errors++;
         $display("FAIL midwr_enter: state %0d ctl %h, required state %0d ctl %h", state, ctl, S_MEMWR, MWRC | SBB);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if (state !== S_START || ctl !== C0) begin
         errors++;
         $display("FAIL midwr_async_reset: state %0d ctl %h, required state %0d ctl %h", state, ctl, S_START, C0);
      end
      @(negedge clk);
      reset = 1'b1; #1;
      checks++;
      if (state !== S_START || ctl !== C0) begin
         errors++;
         $display("FAIL midwr_release: state %0d ctl %h, required state %0d ctl %h", state, ctl, S_START, C0);
      end
      @(negedge clk); #1;
      checks++;
      if (state !== S_FETCH || ctl !== F_W) begin
         errors++;
         $display("FAIL midwr_fetch: state %0d ctl %h, required state %0d ctl %h", state, ctl, S_FETCH, F_W);
      end
   endtask

   initial begin
      reset = 1'b0; op = '0; funct = '0; zero = 1'b0; memready = 1'b0;
      test_reset();
      test_rtype_add();
      test_lw_wait();
      test_branch();
      test_store();
      test_alu_functs();
      test_addi_jump();
      test_timeout();
      test_illegal();
      test_reset_midwr();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle control unit for the next-generation MIPS core. It replaces the single-cycle opcode/funct decode with a state machine that reuses one ALU and one unified memory port. It also adds a request/ready memory handshake with a parametrised timeout and a sticky fault trap. It sits inside the multicycle `mips` top, beside the multicycle datapath, and drives every datapath mux, enable and memory strobe.

## Interface
- TIMEOUT, 16: maximum consecutive cycles a memory state may wait for `memready`; 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT+1) (minimum 1): width of the wait counter.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instr[31:26], valid from DECODE onward (IR output).
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- memready  in  1  memory accepted/completed the current request this cycle.
- memreq  out  1  memory request.
- memwrite  out  1  write request; qualifies `memreq`.
- sb  out  1  byte store; dmem writes addr[1:0] lane only.
- iord  out  1  0 = PC addresses memory, 1 = ALUOut.
- irwrite  out  1  load IR.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = Data register to regfile.
- regwrite  out  1  regfile write enable.
- alusrca  out  1  0 = PC, 1 = A.
- alusrcb  out  2  00 B, 01 const 4, 10 signimm, 11 signimm<<2.
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 011 sll.
- shift  out  1  ALU A-input takes shamt (sll).
- pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target.
- pcen  out  1  PC write enable (pcwrite | branch taken).
- fault  out  1  sticky trap indicator.
- state  out  4  current state encoding, for debug/waveforms.

## Operation
- States and encodings: START=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12, TRAP=15.
- START: all outputs 0. Next state is FETCH.
- FETCH: memreq=1, iord=0, alusrcb=01, add.
  - If memready=1: irwrite=1, pcen=1, pcsrc=00, and the next state is DECODE.
  - Otherwise FETCH holds.
- DECODE: alusrcb=11, add (branch target into ALUOut). Next state by op:
  - 000000 with funct in {100000, 100010, 100100, 100101, 101010, 000000} → EXEC.
  - 100011/101011/101000 → MEMADR.
  - 000100/000101 → BRANCH.
  - 001000 → ADDIEX.
  - 000010 → JUMP.
  - Any other op or funct → TRAP.
- MEMADR: alusrca=1, alusrcb=10, add. lw → MEMRD; sw/sb → MEMWR.
- MEMRD: memreq=1, iord=1. Holds until memready, then → MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next state is FETCH.
- MEMWR: memreq=1, memwrite=1, iord=1, sb=(op==101000). Holds until memready, then → FETCH.
- EXEC: alusrca=1, alusrcb=00, alucontrol from funct. For sll, shift=1 and alucontrol=011. Next state is ALUWB.
- ALUWB: regdst=1, regwrite=1. Next state is FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01.
  - pcen = zero for beq (000100), ~zero for bne (000101).
  - Next state is FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next state is ADDIWB.
- ADDIWB: regdst=0, regwrite=1. Next state is FETCH.
- JUMP: pcsrc=10, pcen=1. Next state is FETCH.
- TRAP: fault=1, all other outputs 0. Held until reset.
- Outputs not listed for a state are 0.
- Outputs are combinational from state, op, funct, zero and memready. No output is registered.

## Timing
- Reset asserted (low): state=START immediately, asynchronously, from any state including mid-handshake. All outputs are 0 while reset is low and in the first cycle after release.
- Zero-wait cycle counts, FETCH through last state inclusive:
  - R-type 4, lw 5, sw/sb 4, beq/bne 3, addi 4, j 3.
  - Each wait cycle adds 1.
- Handshake:
  - `memreq` and its qualifiers (iord, memwrite, sb) stay stable every cycle until the cycle memready=1.
  - memready while memreq=0 is ignored.
- Wait counter:
  - Clears on every state change.
  - Increments in FETCH/MEMRD/MEMWR while memready=0.
  - If it equals TIMEOUT-1 and memready=0, the next state is TRAP.
  - memready=1 in that same cycle wins: normal transition.
  - Counter saturates when TIMEOUT=0.

## Test plan
- Release reset, memready=1, IR=add (op 0, funct 100000) → START, FETCH, DECODE, EXEC, ALUWB, FETCH; ALUWB has regwrite=1, regdst=1; EXEC has alucontrol=010.
- lw with memready low for 3 cycles in FETCH and 2 in MEMRD → memreq high 4 cycles in FETCH, 3 in MEMRD; irwrite/pcen only on the 4th FETCH cycle; 10 cycles total; MEMWB has memtoreg=1.
- beq with zero=1 → pcen=1 in BRANCH; bne with zero=1 → pcen=0; pcsrc=01 in both.
- sb (op 101000) → MEMWR has memreq=1, memwrite=1, sb=1, iord=1; sw has sb=0. sll (funct 000000) → EXEC has shift=1, alucontrol=011.
- TIMEOUT=4, memready held 0 → 4 FETCH cycles, then TRAP; fault=1, memreq=0 until reset. Op 111111 in DECODE → TRAP next cycle.
- Assert reset mid-MEMWR → memreq, memwrite and sb drop to 0 with no clock edge. After release: START, then FETCH.
